serial_chunk_adder: RTL and testbench

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder_if.sv | 26 ++
 rtl/serial_chunk_adder.sv | 98 +++++++++
 tb/tb_serial_chunk_adder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for serial_chunk_adder.
// The master drives the request, and the slave (the adder) returns status and result.
interface serial_chunk_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, a, b, sub, cin,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, a, b, sub, cin,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// The result, carry and overflow update only on completion.
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_chunk_adder_if.slave ca_if
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_d;
  logic [WIDTH-1:0] part_d;
  logic             msb_cin;
  logic             last;

  always_comb begin
    a_chunk = a_q[k_q*CHUNK +: CHUNK];
    b_chunk = b_q[k_q*CHUNK +: CHUNK];
    chunk_d = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    part_d  = part_q;
    part_d[k_q*CHUNK +: CHUNK] = chunk_d[CHUNK-1:0];
    // Carry into the top bit of the chunk, recovered from that bit's sum.
    msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_d[CHUNK-1];
    last    = (k_q == KW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ca_if.start) begin
            a_q     <= ca_if.a;
            b_q     <= ca_if.b ^ {WIDTH{ca_if.sub}};
            c_q     <= ca_if.sub | ca_if.cin;
            k_q     <= '0;
            part_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          part_q <= part_d;
          c_q    <= chunk_d[CHUNK];
          k_q    <= k_q + KW'(1);
          if (last) begin
            sum_q   <= part_d;
            carry_q <= chunk_d[CHUNK];
            ovf_q   <= msb_cin ^ chunk_d[CHUNK];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ca_if.busy     = busy_q;
  assign ca_if.done     = done_q;
  assign ca_if.sum      = sum_q;
  assign ca_if.carry    = carry_q;
  assign ca_if.overflow = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Randomised self-checking bench for serial_chunk_adder.
// It drives a CHUNK=2 instance and a CHUNK=8 instance against an integer-arithmetic reference model.
module tb_serial_chunk_adder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  serial_chunk_adder_if #(.WIDTH(W)) if2 ();
  serial_chunk_adder_if #(.WIDTH(W)) if8 ();

  serial_chunk_adder #(.WIDTH(W), .CHUNK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ca_if (if2)
  );

  serial_chunk_adder #(.WIDTH(W), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .ca_if (if8)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  bit sel;
  logic [W-1:0] hold_sum [2];
  logic         hold_c   [2];
  logic         hold_v   [2];
  logic [W-1:0] cur_a, cur_b;
  logic         cur_sub, cur_cin;

  logic         busy_o, done_o, carry_o, ovf_o;
  logic [W-1:0] sum_o;

  always_comb begin
    busy_o  = sel ? if8.busy     : if2.busy;
    done_o  = sel ? if8.done     : if2.done;
    sum_o   = sel ? if8.sum      : if2.sum;
    carry_o = sel ? if8.carry    : if2.carry;
    ovf_o   = sel ? if8.overflow : if2.overflow;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (chunk%0d) t=%0t: got 0x%0h expected 0x%0h",
                  tag, sel ? 8 : 2, $time, got, exp);
  endtask

  // Reference: plain integer arithmetic, with signed range checks for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      c  = (r > 255);
    end
    s = r[W-1:0];
    v = (sr > 127) || (sr < -128);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    if (sel) begin
      if8.start = st; if8.a = a; if8.b = b; if8.sub = sub; if8.cin = cin;
    end else begin
      if2.start = st; if2.a = a; if2.b = b; if2.sub = sub; if2.cin = cin;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    cur_a = a; cur_b = b; cur_sub = sub; cur_cin = cin;
    drive(1'b1, a, b, sub, cin);
  endtask

  task automatic issue_rand();
    issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Expects a request already driven with start=1; returns in the done cycle.
  task automatic run_op(input bit disturb);
    int n;
    logic [W-1:0] es;
    logic ec, ev;
    n = sel ? 1 : 4;
    model(cur_a, cur_b, cur_sub, cur_cin, es, ec, ev);
    tick();
    drive(1'b0, cur_a, cur_b, cur_sub, cur_cin);
    for (int i = 0; i < n; i++) begin
      check("busy_run", 32'(busy_o), 32'd1);
      check("done_early", 32'(done_o), 32'd0);
      check("sum_hold", 32'(sum_o), 32'(hold_sum[sel]));
      check("carry_hold", 32'(carry_o), 32'(hold_c[sel]));
      if (disturb)
        drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    check("done", 32'(done_o), 32'd1);
    check("busy_done", 32'(busy_o), 32'd0);
    check("sum", 32'(sum_o), 32'(es));
    check("carry", 32'(carry_o), 32'(ec));
    check("overflow", 32'(ovf_o), 32'(ev));
    hold_sum[sel] = es;
    hold_c[sel]   = ec;
    hold_v[sel]   = ev;
    drive(1'b0, cur_a, cur_b, cur_sub, cur_cin);
  endtask

  task automatic idle_cycle();
    tick();
    check("done_pulse", 32'(done_o), 32'd0);
    check("busy_idle", 32'(busy_o), 32'd0);
    check("sum_idle", 32'(sum_o), 32'(hold_sum[sel]));
    check("ovf_idle", 32'(ovf_o), 32'(hold_v[sel]));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_sum"}, 32'(sum_o), 32'd0);
    check({tag, "_carry"}, 32'(carry_o), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 2; i++) begin
      hold_sum[i] = '0;
      hold_c[i]   = 1'b0;
      hold_v[i]   = 1'b0;
    end
    rst_n = 1'b0;
    sel = 1'b1; drive(1'b0, '0, '0, 1'b0, 1'b0);
    sel = 1'b0; drive(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    check_cleared("rst2");
    sel = 1'b1; check_cleared("rst8");
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases on the 2-bit-chunk instance
    issue(8'h01, 8'h01, 1'b0, 1'b0); run_op(1'b0); idle_cycle();
    issue(8'hFF, 8'h01, 1'b0, 1'b1); run_op(1'b0); idle_cycle();
    issue(8'h7F, 8'h01, 1'b0, 1'b0); run_op(1'b0); idle_cycle();
    issue(8'h05, 8'h07, 1'b1, 1'b0); run_op(1'b0); idle_cycle();
    issue(8'h80, 8'h01, 1'b1, 1'b1); run_op(1'b0); idle_cycle();

    // Start and operand changes during RUN are ignored
    issue(8'h3C, 8'h5A, 1'b0, 1'b1); run_op(1'b1); idle_cycle();

    // Back-to-back: start held in the done cycle
    issue(8'h10, 8'h20, 1'b0, 1'b0); run_op(1'b0);
    issue(8'h90, 8'h90, 1'b0, 1'b0); run_op(1'b0); idle_cycle();

    // Reset two cycles into RUN
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, cur_a, cur_b, cur_sub, cur_cin);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    tick();
    check("abort_no_done", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hold_sum[i] = '0;
      hold_c[i]   = 1'b0;
      hold_v[i]   = 1'b0;
    end
    issue(8'h33, 8'hC4, 1'b0, 1'b1); run_op(1'b0); idle_cycle();

    for (int i = 0; i < 40; i++) begin
      issue_rand();
      run_op($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    // Single-chunk instance
    sel = 1'b1;
    issue(8'hFF, 8'h01, 1'b0, 1'b1); run_op(1'b0); idle_cycle();
    issue(8'h7F, 8'h01, 1'b0, 1'b0); run_op(1'b0); idle_cycle();
    issue(8'h80, 8'h01, 1'b1, 1'b0); run_op(1'b0);
    for (int i = 0; i < 20; i++) begin
      issue_rand();
      run_op(1'b0);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
